// File: rtl/fence_sequencer.sv
// Fence sequencer: orders store drain, D$/I$ flush and TLB shootdown
// for FENCE-family instructions, then requests a refetch from commit.
module fence_sequencer #(
  parameter int WT_DCACHE   = 0,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [2:0] req_type_i,
  input  logic       v_i,
  input  logic       stores_empty_i,
  input  logic       abort_i,
  output logic       flush_dcache_o,
  input  logic       flush_dcache_ack_i,
  output logic       flush_icache_o,
  output logic       flush_tlb_o,
  output logic       flush_tlb_vvma_o,
  output logic       flush_tlb_gvma_o,
  output logic       halt_o,
  output logic       done_o,
  output logic       set_pc_commit_o,
  output logic       err_o
);

  localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd1;
  localparam logic [2:0] S_DC    = 3'd2;
  localparam logic [2:0] S_IC    = 3'd3;
  localparam logic [2:0] S_TLB   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [2:0] T_FENCE  = 3'd0;
  localparam logic [2:0] T_FENCEI = 3'd1;
  localparam logic [2:0] T_SFENCE = 3'd2;
  localparam logic [2:0] T_HVVMA  = 3'd3;
  localparam logic [2:0] T_HGVMA  = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    r_type;
  logic          r_v;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  logic [2:0]    w_next;
  logic          w_err_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_accept;
  logic          w_is_fence;
  logic          w_is_fencei;
  logic          w_is_tlb;
  logic          w_timeout;

  assign w_accept    = req_valid_i && (r_state == S_IDLE);
  assign w_is_fence  = (r_type == T_FENCE);
  assign w_is_fencei = (r_type == T_FENCEI);
  assign w_is_tlb    = (r_type == T_SFENCE) ||
                       (r_type == T_HVVMA)  ||
                       (r_type == T_HGVMA);
  assign w_timeout   = (ACK_TIMEOUT != 0) && (r_cnt == TO_LAST);

  always_comb begin
    w_next    = r_state;
    w_err_nxt = r_err;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next    = S_DRAIN;
          w_err_nxt = 1'b0;
        end
      end
      S_DRAIN: begin
        // abort wins over a store buffer that drains in the same cycle
        if (abort_i) begin
          w_next = S_IDLE;
        end else if (stores_empty_i) begin
          if ((w_is_fence || w_is_fencei) && (WT_DCACHE == 0)) begin
            w_next    = S_DC;
            w_cnt_nxt = '0;
          end else if (w_is_fencei) begin
            w_next = S_IC;
          end else if (w_is_tlb) begin
            w_next = S_TLB;
          end else begin
            w_next    = S_DONE;
            w_err_nxt = !w_is_fence;
          end
        end
      end
      S_DC: begin
        if (flush_dcache_ack_i) begin
          w_next = w_is_fencei ? S_IC : S_DONE;
        end else if (w_timeout) begin
          w_next    = S_DONE;
          w_err_nxt = 1'b1;
        end else if (ACK_TIMEOUT != 0) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_IC:    w_next = S_DONE;
      S_TLB:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_type  <= 3'd0;
      r_v     <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_type <= req_type_i;
        r_v    <= v_i;
      end
    end
  end

  // all outputs decode from registered state only
  assign req_ready_o      = (r_state == S_IDLE);
  assign halt_o           = (r_state != S_IDLE);
  assign flush_dcache_o   = (r_state == S_DC);
  assign flush_icache_o   = (r_state == S_IC);
  assign flush_tlb_o      = (r_state == S_TLB) &&
                            (r_type == T_SFENCE) && !r_v;
  assign flush_tlb_vvma_o = (r_state == S_TLB) &&
                            (((r_type == T_SFENCE) && r_v) ||
                             (r_type == T_HVVMA));
  assign flush_tlb_gvma_o = (r_state == S_TLB) &&
                            (r_type == T_HGVMA);
  assign done_o           = (r_state == S_DONE);
  assign set_pc_commit_o  = (r_state == S_DONE);
  assign err_o            = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_fence_sequencer.sv
// Bench for fence_sequencer: directed vector tables, async reset
// corner case, and random traffic against a step-plan model.
module tb_fence_sequencer;

  localparam int WT = 0;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [2:0] typ;
  logic       vin;
  logic       se;
  logic       ab;
  logic       ack;

  logic ready, dc, ic, tlb, vvma, gvma;
  logic halt, done, setpc, err;

  fence_sequencer #(.WT_DCACHE(WT), .ACK_TIMEOUT(TO)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_valid_i       (valid),
    .req_ready_o       (ready),
    .req_type_i        (typ),
    .v_i               (vin),
    .stores_empty_i    (se),
    .abort_i           (ab),
    .flush_dcache_o    (dc),
    .flush_dcache_ack_i(ack),
    .flush_icache_o    (ic),
    .flush_tlb_o       (tlb),
    .flush_tlb_vvma_o  (vvma),
    .flush_tlb_gvma_o  (gvma),
    .halt_o            (halt),
    .done_o            (done),
    .set_pc_commit_o   (setpc),
    .err_o             (err)
  );

  always #5 clk = ~clk;

  // {ready,halt,dc,ic,tlb,vvma,gvma,done,setpc,err}
  logic [9:0] outs;
  assign outs = {ready, halt, dc, ic, tlb,
                 vvma, gvma, done, setpc, err};

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string nm,
                       input logic [9:0] want);
    nvec++;
    if (outs !== want) begin
      nerr++;
      $display("FAIL %s @%0t: got %b want %b",
               nm, $time, outs, want);
    end
  endtask

  // model: on acceptance, a list of steps still to perform
  // 1 drain, 2 dcache flush, 3 icache pulse, 4 tlb pulse, 5 done
  int         plan[$];
  logic [2:0] mtype;
  logic       mv;
  logic       merr;
  int         mwait;

  function automatic logic [9:0] mexp();
    logic [9:0] o;
    o = 10'b0100000000;
    if (plan.size() == 0) return 10'b1000000000;
    case (plan[0])
      2: o[7] = 1'b1;
      3: o[6] = 1'b1;
      4: begin
        if (mtype == 3'd4) o[3] = 1'b1;
        else if (mtype == 3'd3 || mv) o[4] = 1'b1;
        else o[5] = 1'b1;
      end
      5: o[2:0] = {1'b1, 1'b1, merr};
      default: ;
    endcase
    return o;
  endfunction

  task automatic mupd();
    if (plan.size() == 0) begin
      if (valid) begin
        mtype = typ;
        mv    = vin;
        merr  = (typ > 3'd4);
        mwait = 0;
        plan  = {1};
        if (typ <= 3'd1 && WT == 0) plan.push_back(2);
        if (typ == 3'd1) plan.push_back(3);
        if (typ >= 3'd2 && typ <= 3'd4) plan.push_back(4);
        plan.push_back(5);
      end
    end else begin
      case (plan[0])
        1: begin
          if (ab) plan.delete();
          else if (se) void'(plan.pop_front());
        end
        2: begin
          if (ack) void'(plan.pop_front());
          else begin
            mwait++;
            if (TO != 0 && mwait == TO) begin
              plan = {5};
              merr = 1'b1;
            end
          end
        end
        default: void'(plan.pop_front());
      endcase
    end
  endtask

  task automatic cyc(input string nm);
    @(negedge clk);
    check(nm, mexp());
    mupd();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      nm;
    logic       valid;
    logic [2:0] typ;
    logic       vin;
    logic       se;
    logic       ab;
    logic       ack;
    logic [9:0] exp;
  } vec_t;

  vec_t vt[$];

  localparam logic [9:0] O_IDLE = 10'b1000000000;
  localparam logic [9:0] O_BUSY = 10'b0100000000;
  localparam logic [9:0] O_DC   = 10'b0110000000;
  localparam logic [9:0] O_IC   = 10'b0101000000;
  localparam logic [9:0] O_VVMA = 10'b0100010000;
  localparam logic [9:0] O_GVMA = 10'b0100001000;
  localparam logic [9:0] O_DONE = 10'b0100000110;
  localparam logic [9:0] O_DERR = 10'b0100000111;

  task automatic fill();
    // FENCE_I, ack on 4th DC_FLUSH cycle, done 7 cycles on
    vt.push_back('{"fi_acc",  1, 3'd1, 0, 1, 0, 0, O_IDLE});
    vt.push_back('{"fi_drn",  0, 3'd0, 0, 1, 0, 0, O_BUSY});
    vt.push_back('{"fi_dc0",  0, 3'd0, 0, 1, 0, 0, O_DC});
    vt.push_back('{"fi_dc1",  0, 3'd0, 0, 1, 0, 0, O_DC});
    vt.push_back('{"fi_dc2",  0, 3'd0, 0, 1, 0, 0, O_DC});
    vt.push_back('{"fi_dc3",  0, 3'd0, 0, 1, 0, 1, O_DC});
    vt.push_back('{"fi_ic",   0, 3'd0, 0, 1, 0, 0, O_IC});
    vt.push_back('{"fi_done", 0, 3'd0, 0, 1, 0, 0, O_DONE});
    vt.push_back('{"fi_idle", 0, 3'd0, 0, 1, 0, 0, O_IDLE});
    // SFENCE_VMA, v latched 1 then dropped
    vt.push_back('{"sf_acc",  1, 3'd2, 1, 1, 0, 0, O_IDLE});
    vt.push_back('{"sf_drn",  0, 3'd0, 0, 1, 0, 0, O_BUSY});
    vt.push_back('{"sf_tlb",  0, 3'd0, 0, 1, 0, 0, O_VVMA});
    vt.push_back('{"sf_done", 0, 3'd0, 0, 1, 0, 0, O_DONE});
    vt.push_back('{"sf_idle", 0, 3'd0, 0, 1, 0, 0, O_IDLE});
    // FENCE, no ack: timeout after 4 cycles, late ack ignored
    vt.push_back('{"to_acc",  1, 3'd0, 0, 1, 0, 0, O_IDLE});
    vt.push_back('{"to_drn",  0, 3'd0, 0, 1, 0, 0, O_BUSY});
    vt.push_back('{"to_dc0",  0, 3'd0, 0, 1, 0, 0, O_DC});
    vt.push_back('{"to_dc1",  0, 3'd0, 0, 1, 0, 0, O_DC});
    vt.push_back('{"to_dc2",  0, 3'd0, 0, 1, 0, 0, O_DC});
    vt.push_back('{"to_dc3",  0, 3'd0, 0, 1, 0, 0, O_DC});
    vt.push_back('{"to_done", 0, 3'd0, 0, 1, 0, 1, O_DERR});
    vt.push_back('{"to_late", 0, 3'd0, 0, 1, 0, 1, O_IDLE});
    vt.push_back('{"to_idle", 0, 3'd0, 0, 1, 0, 0, O_IDLE});
    // HFENCE_GVMA aborted during drain
    vt.push_back('{"ab_acc",  1, 3'd4, 0, 0, 0, 0, O_IDLE});
    vt.push_back('{"ab_drn0", 0, 3'd0, 0, 0, 0, 0, O_BUSY});
    vt.push_back('{"ab_drn1", 0, 3'd0, 0, 0, 1, 0, O_BUSY});
    vt.push_back('{"ab_idl0", 0, 3'd0, 0, 0, 0, 0, O_IDLE});
    vt.push_back('{"ab_idl1", 0, 3'd0, 0, 0, 0, 0, O_IDLE});
    // illegal type 6
    vt.push_back('{"il_acc",  1, 3'd6, 0, 1, 0, 0, O_IDLE});
    vt.push_back('{"il_drn",  0, 3'd0, 0, 1, 0, 0, O_BUSY});
    vt.push_back('{"il_done", 0, 3'd0, 0, 1, 0, 0, O_DERR});
    // back-to-back: error flag must clear on acceptance
    vt.push_back('{"gv_acc",  1, 3'd4, 0, 1, 0, 0, O_IDLE});
    vt.push_back('{"gv_drn",  0, 3'd0, 0, 1, 0, 0, O_BUSY});
    vt.push_back('{"gv_tlb",  0, 3'd0, 0, 1, 0, 0, O_GVMA});
    vt.push_back('{"gv_done", 0, 3'd0, 0, 1, 0, 0, O_DONE});
    // abort and stores_empty together: abort wins
    vt.push_back('{"pr_acc",  1, 3'd3, 0, 1, 0, 0, O_IDLE});
    vt.push_back('{"pr_drn",  0, 3'd0, 0, 1, 1, 0, O_BUSY});
    vt.push_back('{"pr_idle", 0, 3'd0, 0, 1, 0, 0, O_IDLE});
    // FENCE_I with immediate ack: done after 4 cycles
    vt.push_back('{"fa_acc",  1, 3'd1, 0, 1, 0, 0, O_IDLE});
    vt.push_back('{"fa_drn",  0, 3'd0, 0, 1, 0, 0, O_BUSY});
    vt.push_back('{"fa_dc",   0, 3'd0, 0, 1, 1, 1, O_DC});
    vt.push_back('{"fa_ic",   0, 3'd0, 0, 1, 1, 0, O_IC});
    vt.push_back('{"fa_done", 0, 3'd0, 0, 1, 0, 0, O_DONE});
    vt.push_back('{"fa_idle", 0, 3'd0, 0, 1, 0, 0, O_IDLE});
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    #1;
    check(nm, O_IDLE);
    plan.delete();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    typ   = 3'd0;
    vin   = 1'b0;
    se    = 1'b0;
    ab    = 1'b0;
    ack   = 1'b0;
    fill();
    @(posedge clk);
    #1;
    check("reset", O_IDLE);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vt[i]) begin
      valid = vt[i].valid;
      typ   = vt[i].typ;
      vin   = vt[i].vin;
      se    = vt[i].se;
      ab    = vt[i].ab;
      ack   = vt[i].ack;
      @(negedge clk);
      check(vt[i].nm, vt[i].exp);
      mupd();
      @(posedge clk);
      #1;
    end

    // reset asserted while in DC_FLUSH
    valid = 1'b1; typ = 3'd0; se = 1'b1; ab = 1'b0; ack = 1'b0;
    cyc("rs_acc");
    valid = 1'b0;
    cyc("rs_drn");
    cyc("rs_dc0");
    do_reset("rs_async");
    for (int k = 0; k < 6; k++) cyc("rs_after");

    for (int i = 0; i < 4000; i++) begin
      valid = ($urandom_range(0, 2) != 0);
      typ   = 3'($urandom_range(0, 7));
      vin   = 1'($urandom_range(0, 1));
      se    = ($urandom_range(0, 2) == 0);
      ab    = ($urandom_range(0, 9) == 0);
      ack   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) do_reset("rand_rst");
      cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
